// File: rtl/alu_pkg.sv
// Shared ALU opcodes and datapath width for the ALU/counter/decoder bundle.
package alu_pkg;
   localparam int ALU_W = 4;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_NOT = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_EQ  = 3'b111;
endpackage

// File: rtl/alu4_core.sv
// 8-function ALU with zero/carry/overflow flags; purely combinational, 0 cycles.
// No handshake: the result follows the inputs and is never stalled.
module alu4_core
   import alu_pkg::*;
(
   input  logic [2:0]       fn_i,
   input  logic [ALU_W-1:0] a_i,
   input  logic [ALU_W-1:0] b_i,
   output logic [ALU_W-1:0] res_o,
   output logic             zero_o,
   output logic             ovf_o,
   output logic             carry_o
);
   logic [ALU_W-1:0] b_op;
   logic             cin;
   logic [ALU_W:0]   sum;
   logic             sum_ovf;
   logic             lt;

   // One adder serves ADD, SUB and SLT; everything except ADD subtracts.
   assign b_op = (fn_i == ALU_ADD) ? b_i : ~b_i;
   assign cin  = (fn_i != ALU_ADD);
   assign sum  = {1'b0, a_i} + {1'b0, b_op} + {{ALU_W{1'b0}}, cin};
   assign sum_ovf = (a_i[ALU_W-1] == b_op[ALU_W-1]) & (sum[ALU_W-1] != a_i[ALU_W-1]);
   assign lt      = sum[ALU_W-1] ^ sum_ovf;

   always_comb begin
      res_o   = '0;
      ovf_o   = 1'b0;
      carry_o = 1'b0;
      case (fn_i)
         ALU_ADD, ALU_SUB: begin
            res_o   = sum[ALU_W-1:0];
            carry_o = sum[ALU_W];
            ovf_o   = sum_ovf;
         end
         ALU_NOT: res_o = ~a_i;
         ALU_AND: res_o = a_i & b_i;
         ALU_OR:  res_o = a_i | b_i;
         ALU_XOR: res_o = a_i ^ b_i;
         ALU_SLT: res_o = {{(ALU_W-1){1'b0}}, lt};
         default: res_o = {{(ALU_W-1){1'b0}}, (a_i == b_i)};
      endcase
   end

   assign zero_o = (res_o == '0);
endmodule

// File: rtl/alu_cnt_dec_unit.sv
// Bundles a combinational ALU, a registered 3-bit down counter (1-cycle update)
// and a combinational 3-to-8 decoder; no handshake, nothing ever stalls.
module alu_cnt_dec_unit
   import alu_pkg::*;
#(
   parameter int CNT_W   = 3,
   parameter int CNT_RST = 7
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       alu_fnselec,
   input  logic [ALU_W-1:0] alu_a,
   input  logic [ALU_W-1:0] alu_b,
   output logic [ALU_W-1:0] alu_res,
   output logic             alu_zero,
   output logic             alu_overflow,
   output logic             alu_carry,
   input  logic             counter_en,
   output logic [CNT_W-1:0] dec_counter_out,
   input  logic [2:0]       x,
   input  logic             en,
   output logic [7:0]       y_dec
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   alu4_core u_alu (
      .fn_i    (alu_fnselec),
      .a_i     (alu_a),
      .b_i     (alu_b),
      .res_o   (alu_res),
      .zero_o  (alu_zero),
      .ovf_o   (alu_overflow),
      .carry_o (alu_carry)
   );

   // Wraps 0 -> all ones naturally through modular subtraction.
   always_comb begin
      cnt_d = cnt_q;
      if (counter_en) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= CNT_W'(CNT_RST);
      else     cnt_q <= cnt_d;
   end

   assign dec_counter_out = cnt_q;

   always_comb begin
      y_dec = 8'h00;
      if (en) y_dec = 8'd1 << x;
   end
endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// Self-checking bench for alu_cnt_dec_unit: directed spec vectors plus
// random stimulus against an arithmetic reference model.
module tb_alu_cnt_dec_unit;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] alu_fnselec;
   logic [3:0] alu_a, alu_b, alu_res;
   logic       alu_zero, alu_overflow, alu_carry;
   logic       counter_en;
   logic [2:0] dec_counter_out;
   logic [2:0] x;
   logic       en;
   logic [7:0] y_dec;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_cnt_dec_unit dut (
      .clk(clk), .rst(rst),
      .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b),
      .alu_res(alu_res), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry(alu_carry),
      .counter_en(counter_en), .dec_counter_out(dec_counter_out),
      .x(x), .en(en), .y_dec(y_dec)
   );

   // Reference: {res[3:0], zero, ovf, carry} from integer arithmetic.
   function automatic logic [6:0] alu_model(logic [2:0] op, logic [3:0] a, logic [3:0] b);
      int ua, ub, sa, sb, t;
      logic [3:0] r;
      logic c, v;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      c = 1'b0; v = 1'b0; r = 4'h0;
      case (op)
         3'd0: begin t = ua + ub; r = t[3:0]; c = (t > 15); v = (sa + sb > 7) || (sa + sb < -8); end
         3'd1: begin t = ua - ub; r = t[3:0]; c = (ua >= ub); v = (sa - sb > 7) || (sa - sb < -8); end
         3'd2: r = ~a;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
         default: r = (ua == ub) ? 4'd1 : 4'd0;
      endcase
      return {r, (r == 4'h0), v, c};
   endfunction

   task automatic test_reset();
      rst = 1'b1; counter_en = 1'b1;
      alu_fnselec = 3'd0; alu_a = 4'd2; alu_b = 4'd3;
      @(posedge clk); #1;
      checks++;
      if (dec_counter_out !== 3'd7) begin
         errors++; $display("FAIL reset_cnt got=%0d exp=7", dec_counter_out);
      end
      checks++;
      if (alu_res !== 4'd5) begin
         errors++; $display("FAIL alu_during_rst got=%0d exp=5", alu_res);
      end
      rst = 1'b0; counter_en = 1'b0;
   endtask

   task automatic test_alu_directed();
      logic [2:0] ops  [11] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd6, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4, 3'd5};
      logic [3:0] as   [11] = '{4'h7, 4'hF, 4'h8, 4'h0, 4'h8, 4'h3, 4'h5, 4'h0, 4'hC, 4'hC, 4'hC};
      logic [3:0] bs   [11] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h7, 4'h3, 4'h5, 4'h0, 4'hA, 4'hA, 4'hA};
      // {res, zero, ovf, carry}
      logic [6:0] exps [11] = '{7'b1000_0_1_0, 7'b0000_1_0_1, 7'b0111_0_1_1, 7'b1111_0_0_0,
                               7'b0001_0_0_0, 7'b0000_1_0_0, 7'b0001_0_0_0, 7'b1111_0_0_0,
                               7'b1000_0_0_0, 7'b1110_0_0_0, 7'b0110_0_0_0};
      logic [6:0] got;
      for (int i = 0; i < 11; i++) begin
         alu_fnselec = ops[i]; alu_a = as[i]; alu_b = bs[i];
         #1;
         got = {alu_res, alu_zero, alu_overflow, alu_carry};
         checks++;
         if (got !== exps[i]) begin
            errors++;
            $display("FAIL alu_dir[%0d] op=%0d a=%h b=%h got=%b exp=%b", i, ops[i], as[i], bs[i], got, exps[i]);
         end
      end
   endtask

   task automatic test_alu_random();
      logic [6:0] got, exp;
      for (int i = 0; i < 300; i++) begin
         alu_fnselec = 3'($urandom_range(0, 7));
         alu_a = 4'($urandom); alu_b = 4'($urandom);
         #1;
         got = {alu_res, alu_zero, alu_overflow, alu_carry};
         exp = alu_model(alu_fnselec, alu_a, alu_b);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL alu_rand op=%0d a=%h b=%h got=%b exp=%b", alu_fnselec, alu_a, alu_b, got, exp);
         end
      end
   endtask

   task automatic test_counter_directed();
      int seq [9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
      counter_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         checks++;
         if (dec_counter_out !== 3'(seq[i])) begin
            errors++; $display("FAIL cnt_step[%0d] got=%0d exp=%0d", i, dec_counter_out, seq[i]);
         end
      end
      counter_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dec_counter_out !== 3'd6) begin
         errors++; $display("FAIL cnt_hold got=%0d exp=6", dec_counter_out);
      end
      rst = 1'b1; counter_en = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dec_counter_out !== 3'd7) begin
         errors++; $display("FAIL cnt_rst_prio got=%0d exp=7", dec_counter_out);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (dec_counter_out !== 3'd6) begin
         errors++; $display("FAIL cnt_resume got=%0d exp=6", dec_counter_out);
      end
      counter_en = 1'b0;
   endtask

   task automatic test_counter_random();
      int m;
      m = dec_counter_out;   // continue from the directed test's known value 6
      m = 6;
      for (int i = 0; i < 200; i++) begin
         rst = ($urandom_range(0, 15) == 0);
         counter_en = 1'($urandom);
         @(posedge clk);
         if (rst) m = 7;
         else if (counter_en) m = (m + 7) % 8;
         #1;
         checks++;
         if (dec_counter_out !== 3'(m)) begin
            errors++; $display("FAIL cnt_rand[%0d] got=%0d exp=%0d", i, dec_counter_out, m);
         end
      end
      rst = 1'b0; counter_en = 1'b0;
   endtask

   task automatic test_decoder();
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         x = 3'(i);
         #1;
         checks++;
         if (y_dec !== 8'(1 << i)) begin
            errors++; $display("FAIL dec_x%0d got=%h exp=%h", i, y_dec, 8'(1 << i));
         end
      end
      en = 1'b0; x = 3'd5;
      #1;
      checks++;
      if (y_dec !== 8'h00) begin
         errors++; $display("FAIL dec_disabled got=%h exp=00", y_dec);
      end
      for (int i = 0; i < 20; i++) begin
         en = 1'($urandom); x = 3'($urandom);
         #1;
         checks++;
         if (y_dec !== (en ? 8'(1 << x) : 8'h00)) begin
            errors++; $display("FAIL dec_rand en=%0b x=%0d got=%h", en, x, y_dec);
         end
      end
   endtask

   initial begin
      rst = 1'b0; counter_en = 1'b0; x = 3'd0; en = 1'b0;
      alu_fnselec = 3'd0; alu_a = 4'd0; alu_b = 4'd0;
      @(negedge clk);
      test_reset();
      test_alu_directed();
      test_counter_directed();
      test_counter_random();
      test_alu_random();
      test_decoder();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
